// File: rtl/sio_dir_scheduler.sv
// Direction owner for one bidirectional SPI data line: round-robin TX/RX arbitration with
// released turnaround cycles on every direction change. Optional macro: SIO_CONTENTION_CHECK_EN.
module sio_dir_scheduler #(
  parameter int TURN_CYCLES = 2,  // legal 1..15
  parameter int LEN_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tx_req,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             tx_bit,
  input  logic             rx_req,
  input  logic [LEN_W-1:0] rx_len,
  output logic             rx_valid,
  output logic             rx_bit,
  output logic             grant_tx,
  output logic             grant_rx,
  output logic             busy,
  output logic             sio_o,
  output logic             sio_oe,
  input  logic             sio_i,
  input  logic             err_clr,
  output logic             err_contention
);

  typedef enum logic [1:0] {IDLE, TURN, DRIVE, RECV} state_t;
  typedef enum logic {DIR_RX = 1'b0, DIR_TX = 1'b1} dir_t;

  localparam logic [3:0]       TURN_LOAD = 4'(TURN_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_t           state;
  dir_t             last_dir;
  dir_t             rr_prio;
  dir_t             pend_dir;
  logic [LEN_W-1:0] bit_cnt;
  logic [3:0]       turn_cnt;
  logic             drove;

  dir_t             grant_dir;
  logic [LEN_W-1:0] grant_len;
  logic             grant_any;
  logic             keep_oe;
  logic             tx_fire;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant_tx = 1'b0;
    grant_rx = 1'b0;
    if (state == IDLE) begin
      if (tx_req && rx_req) begin
        grant_tx = (rr_prio == DIR_TX);
        grant_rx = (rr_prio == DIR_RX);
      end else begin
        grant_tx = tx_req;
        grant_rx = rx_req;
      end
    end
  end

  assign grant_any = grant_tx | grant_rx;
  assign grant_dir = grant_tx ? DIR_TX : DIR_RX;
  assign grant_len = grant_tx ? tx_len : rx_len;
  // TX following TX keeps the line driven; the new burst takes over without a release.
  assign keep_oe   = grant_tx && (grant_len != '0) && (last_dir == DIR_TX);
  assign tx_ready  = (state == DRIVE) && (bit_cnt != '0);
  assign tx_fire   = tx_valid && tx_ready;
  assign busy      = (state != IDLE) || sio_oe;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state    <= IDLE;
      last_dir <= DIR_RX;
      rr_prio  <= DIR_TX;
      pend_dir <= DIR_RX;
      bit_cnt  <= '0;
      turn_cnt <= '0;
      drove    <= 1'b0;
      sio_o    <= 1'b0;
      sio_oe   <= 1'b0;
      rx_valid <= 1'b0;
      rx_bit   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!keep_oe) sio_oe <= 1'b0;
          if (grant_any) begin
            if (tx_req && rx_req) rr_prio <= grant_tx ? DIR_RX : DIR_TX;
            // A zero-length grant is acknowledged only; ownership does not change.
            if (grant_len != '0) begin
              bit_cnt  <= grant_len;
              pend_dir <= grant_dir;
              drove    <= 1'b0;
              if (grant_dir != last_dir) begin
                state    <= TURN;
                turn_cnt <= TURN_LOAD;
              end else begin
                state <= grant_tx ? DRIVE : RECV;
              end
            end
          end
        end

        TURN: begin
          sio_oe <= 1'b0;
          if (turn_cnt == '0) state <= (pend_dir == DIR_TX) ? DRIVE : RECV;
          else turn_cnt <= turn_cnt - 4'd1;
        end

        DRIVE: begin
          if (tx_fire) begin
            sio_o   <= tx_bit;
            sio_oe  <= 1'b1;
            drove   <= 1'b1;
            bit_cnt <= bit_cnt - LEN_ONE;
            if (bit_cnt == LEN_ONE) begin
              state    <= IDLE;
              last_dir <= DIR_TX;
            end
          end else if (!drove) begin
            // Before this burst's first bit, a late tx_valid leaves the line released.
            sio_oe <= 1'b0;
          end
        end

        RECV: begin
          sio_oe   <= 1'b0;
          rx_bit   <= sio_i;
          rx_valid <= 1'b1;
          if (bit_cnt != '0) bit_cnt <= bit_cnt - LEN_ONE;
          if (bit_cnt <= LEN_ONE) begin
            state    <= IDLE;
            last_dir <= DIR_RX;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIO_CONTENTION_CHECK_EN
  logic oe_prev;

  // Only judge the pad once our driver has owned it for a full cycle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      oe_prev        <= 1'b0;
      err_contention <= 1'b0;
    end else begin
      oe_prev <= sio_oe;
      if (sio_oe && oe_prev && (sio_i != sio_o)) err_contention <= 1'b1;
      else if (err_clr) err_contention <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_contention = 1'b0;
`endif

endmodule

// File: tb/tb_sio_dir_scheduler.sv
// Directed bench for sio_dir_scheduler (TURN_CYCLES=2, LEN_W=8); expectations hand-derived.
module tb_sio_dir_scheduler;
  localparam int LEN_W = 8;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             tx_req, tx_valid, tx_ready, tx_bit;
  logic             rx_req, rx_valid, rx_bit;
  logic [LEN_W-1:0] tx_len, rx_len;
  logic             grant_tx, grant_rx, busy;
  logic             sio_o, sio_oe, sio_i;
  logic             err_clr, err_contention;
  logic             remote, force_low;

  int               checks;
  int               errors;
  int               hs_cnt;
  logic [63:0]      tr_oe, tr_o, tr_rv, tr_rb, tr_gt, tr_gr, tr_busy, tr_err;

  // Pad model: our driver wins when enabled, else the remote value; force_low models a fight.
  assign sio_i = force_low ? 1'b0 : (sio_oe ? sio_o : remote);

  always #5 sys_clk = ~sys_clk;

  sio_dir_scheduler #(.TURN_CYCLES(2), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tx_req(tx_req), .tx_len(tx_len), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_bit(tx_bit),
    .rx_req(rx_req), .rx_len(rx_len), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .grant_tx(grant_tx), .grant_rx(grant_rx), .busy(busy),
    .sio_o(sio_o), .sio_oe(sio_oe), .sio_i(sio_i),
    .err_clr(err_clr), .err_contention(err_contention)
  );

  task automatic clear_inputs();
    tx_req = 0; rx_req = 0; tx_valid = 0; tx_bit = 0; tx_len = '0; rx_len = '0;
    remote = 0; force_low = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    clear_inputs();
    sys_rst = 0;
    @(negedge sys_clk);
    sys_rst = 1;
  endtask

  // Cycle c starts at a negedge; requests drop after their grant unless keep is set.
  task automatic run_seq(input int n, input logic treq, input logic [LEN_W-1:0] tlen,
                         input logic rreq, input logic [LEN_W-1:0] rlen, input logic keep,
                         input logic [63:0] tpat, input logic [63:0] rpat,
                         input logic [63:0] fpat, input int gap_at, input int gap_len);
    logic tx_done, rx_done;
    int   gap_left;
    tx_done = 0; rx_done = 0; gap_left = gap_len; hs_cnt = 0;
    tr_oe = '0; tr_o = '0; tr_rv = '0; tr_rb = '0;
    tr_gt = '0; tr_gr = '0; tr_busy = '0; tr_err = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge sys_clk);
      tx_req = treq && (keep || !tx_done);
      rx_req = rreq && (keep || !rx_done);
      tx_len = tlen;
      rx_len = rlen;
      if (tx_ready && hs_cnt == gap_at && gap_left > 0) begin
        tx_valid = 0;
        gap_left--;
      end else begin
        tx_valid = 1;
      end
      tx_bit    = tpat[hs_cnt];
      remote    = rpat[c];
      force_low = fpat[c];
      #1;
      tr_oe[c] = sio_oe;   tr_o[c] = sio_o;   tr_rv[c] = rx_valid; tr_rb[c] = rx_bit;
      tr_gt[c] = grant_tx; tr_gr[c] = grant_rx; tr_busy[c] = busy; tr_err[c] = err_contention;
      if (grant_tx) tx_done = 1;
      if (grant_rx) rx_done = 1;
      if (tx_ready && tx_valid) hs_cnt++;
    end
    force_low = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    sys_rst = 1;
    #1 sys_rst = 0;
    #2;
    checks++;
    if ({sio_oe, sio_o, tx_ready, rx_valid, rx_bit} !== 5'b0) begin
      errors++; $display("FAIL reset_line got %b want 00000", {sio_oe, sio_o, tx_ready, rx_valid, rx_bit});
    end
    checks++;
    if ({grant_tx, grant_rx, busy, err_contention} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {grant_tx, grant_rx, busy, err_contention});
    end
    @(negedge sys_clk);
    sys_rst = 1;
  endtask

  // Grant at c0, released c1..c2, first bit on line c4, last c11, oe low c12.
  task automatic test_tx_burst();
    do_reset();
    run_seq(16, 1, 8, 0, 0, 0, 64'hA5, '0, '0, -1, 0);
    checks++;
    if (tr_gt[15:0] !== 16'h0001) begin errors++; $display("FAIL tx_grant got %h want 0001", tr_gt[15:0]); end
    checks++;
    if (tr_oe[15:0] !== 16'h0FF0) begin errors++; $display("FAIL tx_oe got %h want 0ff0", tr_oe[15:0]); end
    checks++;
    if (tr_o[11:4] !== 8'hA5) begin errors++; $display("FAIL tx_bits got %h want a5", tr_o[11:4]); end
    checks++;
    if (tr_busy[12:0] !== 13'h0FFE) begin errors++; $display("FAIL tx_busy got %h want 0ffe", tr_busy[12:0]); end
    checks++;
    if (hs_cnt !== 8) begin errors++; $display("FAIL tx_handshakes got %0d want 8", hs_cnt); end
  endtask

  // tx_valid low 3 cycles after the third bit: line held continuously for 11 cycles.
  task automatic test_tx_stall();
    do_reset();
    run_seq(18, 1, 8, 0, 0, 0, 64'hA5, '0, '0, 3, 3);
    checks++;
    if (tr_oe[17:0] !== 18'h07FF0) begin errors++; $display("FAIL stall_oe got %h want 07ff0", tr_oe[17:0]); end
    checks++;
    if (tr_o[14:4] !== 11'b101_0011_1101) begin
      errors++; $display("FAIL stall_bits got %b want 10100111101", tr_o[14:4]);
    end
    checks++;
    if (hs_cnt !== 8) begin errors++; $display("FAIL stall_handshakes got %0d want 8", hs_cnt); end
  endtask

  // TX(4) granted first, queued RX(4) granted at c7, two released cycles, RECV c10..c13.
  task automatic test_tx_then_rx();
    do_reset();
    run_seq(16, 1, 4, 1, 4, 0, 64'h3, 64'h2C00, '0, -1, 0);
    checks++;
    if ({tr_gt[15:0], tr_gr[15:0]} !== {16'h0001, 16'h0080}) begin
      errors++; $display("FAIL trx_grants got %h/%h want 0001/0080", tr_gt[15:0], tr_gr[15:0]);
    end
    checks++;
    if (tr_oe[15:0] !== 16'h00F0) begin errors++; $display("FAIL trx_oe got %h want 00f0", tr_oe[15:0]); end
    checks++;
    if (tr_o[7:4] !== 4'b0011) begin errors++; $display("FAIL trx_txbits got %b want 0011", tr_o[7:4]); end
    checks++;
    if (tr_rv[15:0] !== 16'h7800) begin errors++; $display("FAIL trx_rx_valid got %h want 7800", tr_rv[15:0]); end
    checks++;
    if (tr_rb[14:11] !== 4'b1011) begin errors++; $display("FAIL trx_rx_bits got %b want 1011", tr_rb[14:11]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    run_seq(16, 1, 1, 1, 1, 1, '0, '0, '0, -1, 0);
    checks++;
    if (tr_gt[15:0] !== 16'h0101) begin errors++; $display("FAIL rr_tx got %h want 0101", tr_gt[15:0]); end
    checks++;
    if (tr_gr[15:0] !== 16'h1010) begin errors++; $display("FAIL rr_rx got %h want 1010", tr_gr[15:0]); end
  endtask

  // Zero-length grant must not move last_dir: following RX starts with no turnaround.
  task automatic test_zero_len();
    do_reset();
    run_seq(3, 1, 0, 0, 0, 0, '0, '0, '0, -1, 0);
    checks++;
    if ({tr_gt[2:0], tr_busy[2:0], tr_oe[2:0]} !== 9'b001_000_000) begin
      errors++; $display("FAIL zero_len got %b want 001000000", {tr_gt[2:0], tr_busy[2:0], tr_oe[2:0]});
    end
    run_seq(4, 0, 0, 1, 1, 0, '0, '0, '0, -1, 0);
    checks++;
    if ({tr_gr[3:0], tr_rv[3:0]} !== 8'b0001_0100) begin
      errors++; $display("FAIL zero_then_rx got %b want 00010100", {tr_gr[3:0], tr_rv[3:0]});
    end
  endtask

  // Repeated TX bursts: no release between owners once the line is first driven.
  task automatic test_back_to_back();
    do_reset();
    run_seq(14, 1, 2, 0, 0, 1, '1, '0, '0, -1, 0);
    checks++;
    if (tr_gt[13:0] !== 14'h0921) begin errors++; $display("FAIL b2b_grants got %h want 0921", tr_gt[13:0]); end
    checks++;
    if (tr_oe[13:0] !== 14'h3FF0) begin errors++; $display("FAIL b2b_oe got %h want 3ff0", tr_oe[13:0]); end
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    run_seq(9, 1, 8, 0, 0, 0, '1, '0, '0, -1, 0);
    checks++;
    if ({tr_oe[8], tx_ready} !== 2'b11) begin
      errors++; $display("FAIL mid_drive got %b want 11", {tr_oe[8], tx_ready});
    end
    #1 sys_rst = 0;
    #1;
    checks++;
    if ({sio_oe, busy, tx_ready} !== 3'b000) begin
      errors++; $display("FAIL async_reset got %b want 000", {sio_oe, busy, tx_ready});
    end
    clear_inputs();
    @(negedge sys_clk);
    sys_rst = 1;
    run_seq(6, 0, 0, 1, 2, 0, '0, 64'h2, '0, -1, 0);
    checks++;
    if ({tr_gr[0], tr_rv[5:0]} !== 7'b1_001100) begin
      errors++; $display("FAIL rx_after_reset got %b want 1001100", {tr_gr[0], tr_rv[5:0]});
    end
    checks++;
    if (tr_rb[3:2] !== 2'b01) begin errors++; $display("FAIL rx_after_reset_bits got %b want 01", tr_rb[3:2]); end
  endtask

  // Pad forced low on c5..c6 while driving 1; oe has been high since c4.
  task automatic test_contention();
    logic [11:0] exp_trace;
    logic        exp_hold;
`ifdef SIO_CONTENTION_CHECK_EN
    exp_trace = 12'hFC0;
    exp_hold  = 1'b1;
`else
    exp_trace = 12'h000;
    exp_hold  = 1'b0;
`endif
    do_reset();
    run_seq(12, 1, 8, 0, 0, 0, '1, '0, 64'h60, -1, 0);
    checks++;
    if (tr_err[11:0] !== exp_trace) begin
      errors++; $display("FAIL contention_set got %h want %h", tr_err[11:0], exp_trace);
    end
    @(negedge sys_clk);
    checks++;
    if (err_contention !== exp_hold) begin
      errors++; $display("FAIL contention_sticky got %b want %b", err_contention, exp_hold);
    end
    err_clr = 1;
    @(negedge sys_clk);
    err_clr = 0;
    #1;
    checks++;
    if (err_contention !== 1'b0) begin errors++; $display("FAIL contention_clr got %b want 0", err_contention); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_tx_burst();
    test_tx_stall();
    test_tx_then_rx();
    test_round_robin();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_drive();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
